inst_cache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between instruction memory and the core's fetch port.

---
 rtl/inst_cache_dm.sv | 163 ++++++++++++++++
 tb/tb_inst_cache_dm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_dm.sv
// -----------------------------------------------------------------------------
// inst_cache_dm
//   Direct-mapped, read-only instruction cache between instruction memory and
//   the core's fetch port. A hit returns the instruction combinationally in the
//   same cycle. A miss stalls the core and refills the whole line, one word per
//   memory req/ack beat, before the lookup is repeated.
//
// Ports
//   clk         in   1     clock, rising edge
//   reset       in   1     asynchronous reset, active low
//   addr_i      in   ADDR  fetch word address
//   inst_o      out  WORD  instruction at addr_i (0 when not a hit)
//   stall_o     out  1     1 = inst_o not valid this cycle, core must hold
//   flush_i     in   1     invalidate all lines
//   mem_req_o   out  1     refill read request
//   mem_addr_o  out  ADDR  refill word address
//   mem_ack_i   in   1     word accepted; mem_data_i valid this cycle
//   mem_data_i  in   WORD  refill data
// -----------------------------------------------------------------------------
module inst_cache_dm #(
    parameter int WORD  = 32,
    parameter int ADDR  = 32,
    parameter int LINES = 16,
    parameter int WPL   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ADDR-1:0] addr_i,
    output logic [WORD-1:0] inst_o,
    output logic            stall_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [ADDR-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [WORD-1:0] mem_data_i
);

    localparam int IDX  = $clog2(LINES);
    localparam int OFF  = $clog2(WPL);
    localparam int TAGW = ADDR - OFF - IDX;
    localparam int LNW  = ADDR - OFF;              // line address width

    typedef enum logic {IDLE, REFILL} state_e;

    // Lookup address split
    logic [OFF-1:0]  a_off;
    logic [IDX-1:0]  a_idx;
    logic [TAGW-1:0] a_tag;

    assign a_off = addr_i[OFF-1:0];
    assign a_idx = addr_i[OFF+IDX-1:OFF];
    assign a_tag = addr_i[ADDR-1:OFF+IDX];

    // Control state
    state_e           state_q, state_d;
    logic [LNW-1:0]   line_q, line_d;              // latched line being refilled
    logic [OFF-1:0]   cnt_q, cnt_d;                // refill word counter
    logic             pend_q, pend_d;              // flush seen during refill
    logic [LINES-1:0] valid_q, valid_d;

    // Storage without reset
    logic [WORD-1:0]  data_q [LINES*WPL];
    logic [TAGW-1:0]  tag_q  [LINES];

    logic             data_we;
    logic             tag_we;
    logic [IDX-1:0]   r_idx;
    logic [TAGW-1:0]  r_tag;
    logic             hit;

    assign r_idx = line_q[IDX-1:0];
    assign r_tag = line_q[LNW-1:IDX];

    // The state term keeps the core stalled for the whole refill, whatever
    // addr_i points at meanwhile.
    assign hit     = (state_q == IDLE) && valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign stall_o = ~hit;
    assign inst_o  = hit ? data_q[{a_idx, a_off}] : '0;

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    // Flush wins over a miss; the miss is retried next cycle.
                    valid_d = '0;
                end else if (!hit) begin
                    state_d        = REFILL;
                    line_d         = addr_i[ADDR-1:OFF];
                    cnt_d          = '0;
                    pend_d         = 1'b0;
                    // The old line is overwritten word by word, so drop it now.
                    valid_d[a_idx] = 1'b0;
                end
            end

            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {line_q, cnt_q};
                if (flush_i) begin
                    pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF'(1);
                    if (cnt_q == OFF'(WPL - 1)) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                        pend_d  = 1'b0;
                        if (pend_q || flush_i) begin
                            valid_d = '0;
                        end else begin
                            valid_d[r_idx] = 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: data and tag arrays are deliberately not reset; the valid bits
    // alone decide whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[{r_idx, cnt_q}] <= mem_data_i;
        end
        if (tag_we) begin
            tag_q[r_idx] <= r_tag;
        end
    end

endmodule

// File: tb/tb_inst_cache_dm.sv
module tb_inst_cache_dm;

    localparam int WORD  = 32;
    localparam int ADDR  = 32;
    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        stall_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: which line address each index currently holds.
    bit          m_valid [LINES];
    logic [29:0] m_line  [LINES];

    inst_cache_dm #(
        .WORD (WORD),
        .ADDR (ADDR),
        .LINES(LINES),
        .WPL  (WPL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_i),
        .inst_o    (inst_o),
        .stall_o   (stall_o),
        .flush_i   (flush_i),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i (mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Static instruction memory contents.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = int'(a[5:2]);
        return m_valid[i] && (m_line[i] == a[31:2]);
    endfunction

    function automatic void model_flush();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch address a until it hits. period: ack on every period-th refill
    // cycle. flush_cyc: refill cycle (first refill only) carrying flush_i.
    // wiggle: drive random addr_i during refill. stalls: stalled cycles seen.
    task automatic fetch(input logic [31:0] a, input int period, input int flush_cyc,
                         input bit wiggle, output int stalls);
        bit          hit;
        bit          pend;
        bit          done;
        logic [29:0] line;
        int          beats;
        int          idx;
        stalls = 0;
        done   = 1'b0;
        for (int iter = 0; iter < 4 && !done; iter++) begin
            addr_i     = a;
            flush_i    = 1'b0;
            mem_ack_i  = 1'($urandom);       // must be ignored in IDLE
            mem_data_i = $urandom;
            @(negedge clk);
            hit = model_hit(a);
            check("lookup_stall", 32'(stall_o), 32'(!hit));
            check("lookup_inst", inst_o, hit ? memf(a) : 32'h0);
            check("lookup_req", 32'(mem_req_o), 32'h0);
            if (!hit) stalls++;
            next_cycle();
            if (hit) begin
                done = 1'b1;
            end else begin
                line         = a[31:2];
                idx          = int'(a[5:2]);
                m_valid[idx] = 1'b0;
                pend         = 1'b0;
                beats        = 0;
                for (int cyc = 0; beats < WPL; cyc++) begin
                    mem_ack_i  = ((cyc % period) == period - 1);
                    mem_data_i = mem_ack_i ? memf({line, 2'(beats)}) : $urandom;
                    flush_i    = (iter == 0) && (cyc == flush_cyc);
                    addr_i     = wiggle ? 32'($urandom_range(0, 255)) : a;
                    @(negedge clk);
                    check("refill_req", 32'(mem_req_o), 32'h1);
                    check("refill_addr", mem_addr_o, {line, 2'(beats)});
                    check("refill_stall", 32'(stall_o), 32'h1);
                    check("refill_inst", inst_o, 32'h0);
                    stalls++;
                    if (flush_i) pend = 1'b1;
                    if (mem_ack_i) beats++;
                    next_cycle();
                end
                if (pend) begin
                    model_flush();
                end else begin
                    m_valid[idx] = 1'b1;
                    m_line[idx]  = line;
                end
            end
        end
        mem_ack_i = 1'b0;
        flush_i   = 1'b0;
        check("fetch_completes", 32'(done), 32'h1);
    endtask

    initial begin
        int s;
        logic [31:0] a;
        int period;
        int fc;

        // Reset state
        reset      = 1'b0;
        addr_i     = 32'h5;
        flush_i    = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        model_flush();
        @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'h1);
        check("rst_inst", inst_o, 32'h0);
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_maddr", mem_addr_o, 32'h0);
        next_cycle();
        mem_ack_i = 1'b0;
        reset     = 1'b1;

        // Cold miss at 0x5, one ack per cycle: 4 beats + 1 stall cycles
        fetch(32'h5, 1, -1, 1'b0, s);
        check("cold_stall_cycles", 32'(s), 32'd5);

        // Other words of the same line hit immediately
        fetch(32'h4, 1, -1, 1'b0, s);
        check("hit4_stalls", 32'(s), 32'd0);
        fetch(32'h6, 1, -1, 1'b0, s);
        check("hit6_stalls", 32'(s), 32'd0);
        fetch(32'h7, 1, -1, 1'b0, s);
        check("hit7_stalls", 32'(s), 32'd0);

        // Same index, other tag: evicts, then 0x5 misses again
        fetch(32'h45, 1, -1, 1'b0, s);
        check("evict_stalls", 32'(s), 32'd5);
        fetch(32'h5, 1, -1, 1'b0, s);
        check("reload_stalls", 32'(s), 32'd5);

        // Slow memory: ack every 3rd cycle
        fetch(32'h21, 3, -1, 1'b0, s);
        check("slow_stall_cycles", 32'(s), 32'd13);

        // Flush at the 2nd ack of a refill of 0x8: refill twice
        fetch(32'h8, 1, 1, 1'b0, s);
        check("flush_refill_stalls", 32'(s), 32'd10);

        // Flush together with a hit in IDLE
        addr_i  = 32'h8;
        flush_i = 1'b1;
        @(negedge clk);
        check("flushhit_stall", 32'(stall_o), 32'h0);
        check("flushhit_inst", inst_o, memf(32'h8));
        next_cycle();
        flush_i = 1'b0;
        model_flush();
        fetch(32'h8, 1, -1, 1'b0, s);
        check("after_flushhit_stalls", 32'(s), 32'd5);

        // Flush together with a miss in IDLE: flush wins, refill one cycle later
        addr_i  = 32'h30;
        flush_i = 1'b1;
        @(negedge clk);
        check("flushmiss_stall", 32'(stall_o), 32'h1);
        check("flushmiss_req", 32'(mem_req_o), 32'h0);
        next_cycle();
        flush_i = 1'b0;
        model_flush();
        fetch(32'h30, 1, -1, 1'b0, s);
        check("flushmiss_stalls", 32'(s), 32'd5);

        // Reset after the 2nd ack of a refill of 0x5
        addr_i = 32'h5;
        @(negedge clk);
        check("rstmid_miss", 32'(stall_o), 32'h1);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            mem_ack_i  = 1'b1;
            mem_data_i = memf(32'h4 + 32'(b));
            @(negedge clk);
            check("rstmid_addr", mem_addr_o, 32'h4 + 32'(b));
            next_cycle();
        end
        reset     = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req_o), 32'h0);
        check("rstmid_stall", 32'(stall_o), 32'h1);
        check("rstmid_inst", inst_o, 32'h0);
        check("rstmid_maddr", mem_addr_o, 32'h0);
        @(negedge clk);
        check("rstmid_req_hold", 32'(mem_req_o), 32'h0);
        next_cycle();
        reset = 1'b1;
        model_flush();
        fetch(32'h5, 1, -1, 1'b0, s);
        check("post_rst_stalls", 32'(s), 32'd5);
        fetch(32'h30, 1, -1, 1'b0, s);
        check("post_rst_lost_line", 32'(s), 32'd5);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a       = 32'($urandom_range(0, 191));
                addr_i  = a;
                flush_i = 1'b1;
                @(negedge clk);
                check("rnd_flush_stall", 32'(stall_o), 32'(!model_hit(a)));
                next_cycle();
                flush_i = 1'b0;
                model_flush();
            end
            a      = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 191));
            period = int'($urandom_range(1, 3));
            fc     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4 * period - 1)) : -1;
            fetch(a, period, fc, 1'($urandom), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
